// File: rtl/ahb_pkg.sv
// Shared AHB encodings, burst-master state enum and command legality check.
package ahb_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001
    } hburst_e;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'b000,
        SIZE_HALF = 3'b001,
        SIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_LAST,
        S_ERR
    } state_e;

    // A command is rejected if too wide, too long or misaligned for its size.
    function automatic logic cmd_bad(
        input logic [2:0] size,
        input logic [4:0] len,
        input logic [1:0] lo,
        input int         max_beats
    );
        logic mis;
        mis = (size == SIZE_HALF && lo[0]) ||
              (size == SIZE_WORD && lo != 2'b00);
        return (size > SIZE_WORD) || (int'(len) + 1 > max_beats) || mis;
    endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Next-beat address for an incrementing burst and 1 KB boundary detection.
module ahb_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    output logic [ADDR_W-1:0] addr_nxt,
    output logic              cross_1k
);

    assign addr_nxt = addr + (ADDR_W'(1) << size);
    assign cross_1k = (addr_nxt[9:0] == 10'd0);

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: one command in, SINGLE/INCR burst out.
// AHB_BURST_MASTER_BUSY_EN: write-data stalls show BUSY instead of IDLE+NONSEQ.
module ahb_burst_master
    import ahb_pkg::*;
#(
    parameter int MAX_BEATS = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [4:0]        cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [31:0]       wdata,
    output logic              rdata_valid,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [1:0]        HTRANS,
    output logic [31:0]       HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [31:0]       HRDATA
);

    localparam int CW = $clog2(MAX_BEATS) + 1;

`ifdef AHB_BURST_MASTER_BUSY_EN
    localparam htrans_e STALL_TR = TR_BUSY;
`else
    localparam htrans_e STALL_TR = TR_IDLE;
`endif

    state_e            state, state_nxt;
    htrans_e           tr, tr_raw, tr_hold_q;
    logic              bad_q, hold_q, dph_q, nseq_q;
    logic [4:0]        len_q;
    logic [CW-1:0]     cnt_q;
    logic [ADDR_W-1:0] addr_nxt;
    logic              cross_1k, bad_w, hs, fire, last, err_in, wok;

    ahb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr     (HADDR),
        .size     (HSIZE),
        .addr_nxt (addr_nxt),
        .cross_1k (cross_1k)
    );

    assign bad_w  = cmd_bad(cmd_size, cmd_len, cmd_addr[1:0], MAX_BEATS);
    assign hs     = cmd_valid && cmd_ready;
    assign last   = (cnt_q == CW'(len_q));
    assign err_in = HRESP && dph_q;
    assign wok    = !HWRITE || wdata_valid;
    assign HTRANS = tr;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_ADDR;
            S_ADDR: begin
                if (bad_q)     state_nxt = S_IDLE;
                else if (fire) state_nxt = last ? S_LAST : S_BURST;
            end
            S_BURST: begin
                if (err_in)            state_nxt = S_ERR;
                else if (fire && last) state_nxt = S_LAST;
            end
            S_LAST: begin
                if (err_in)      state_nxt = S_ERR;
                else if (HREADY) state_nxt = S_IDLE;
            end
            S_ERR:   if (HREADY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tr_raw = TR_IDLE;
        unique case (state)
            S_ADDR:  if (!bad_q && wok) tr_raw = TR_NONSEQ;
            S_BURST: begin
                if (wok) tr_raw = nseq_q ? TR_NONSEQ : TR_SEQ;
                else     tr_raw = STALL_TR;
            end
            default: tr_raw = TR_IDLE;
        endcase
        // A transfer shown while the slave stalled must be repeated unchanged.
        if (hold_q && (state == S_ADDR || state == S_BURST)) tr = tr_hold_q;
        else                                                  tr = tr_raw;
        fire        = (tr == TR_NONSEQ || tr == TR_SEQ) && HREADY && !err_in;
        cmd_ready   = (state == S_IDLE);
        wdata_ready = fire && HWRITE;
        rdata_valid = dph_q && !HWRITE && HREADY && !HRESP;
        rdata       = rdata_valid ? HRDATA : 32'd0;
        err         = (state == S_ADDR && bad_q) || (state == S_ERR && HREADY);
        done        = err || (state == S_LAST && HREADY && !HRESP);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= 3'd0;
            HBURST    <= 3'd0;
            HWDATA    <= 32'd0;
            bad_q     <= 1'b0;
            len_q     <= 5'd0;
            cnt_q     <= '0;
            nseq_q    <= 1'b0;
            hold_q    <= 1'b0;
            tr_hold_q <= TR_IDLE;
            dph_q     <= 1'b0;
        end else begin
            hold_q    <= !HREADY;
            tr_hold_q <= tr;
            if (HREADY) dph_q <= fire;
            if (hs) begin
                bad_q  <= bad_w;
                len_q  <= cmd_len;
                cnt_q  <= '0;
                nseq_q <= 1'b0;
                if (!bad_w) begin
                    HADDR  <= cmd_addr;
                    HWRITE <= cmd_write;
                    HSIZE  <= cmd_size;
                    HBURST <= (cmd_len == 5'd0) ? BURST_SINGLE : BURST_INCR;
                end
            end else if (fire) begin
                if (HWRITE) HWDATA <= wdata;
                if (!last) begin
                    cnt_q  <= cnt_q + CW'(1);
                    HADDR  <= addr_nxt;
                    nseq_q <= cross_1k;
                end
            end else if (state == S_BURST && tr == TR_IDLE) begin
                nseq_q <= 1'b1;
            end
        end
    end

endmodule
